// File: rtl/hx8352_bus_if_if.sv
`default_nettype none
// ============================================================================
// Module      : hx8352_bus_if_if
// Description : Request/response handshake between the HX8352 main FSM
//               (master) and the 8080-style bus engine (slave).
//               bus_step        - request strobe (master -> slave)
//               command_or_data - 0 command / 1 data (master -> slave)
//               read_req        - 1 read / 0 write (master -> slave)
//               data_to_write   - write payload (master -> slave)
//               bus_done        - one-cycle completion pulse (slave -> master)
//               busy            - engine not idle (slave -> master)
//               read_data       - last sampled read value (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface hx8352_bus_if_if;
    logic        bus_step;
    logic        command_or_data;
    logic        read_req;
    logic [15:0] data_to_write;
    logic        bus_done;
    logic        busy;
    logic [15:0] read_data;

    modport master (
        output bus_step,
        output command_or_data,
        output read_req,
        output data_to_write,
        input  bus_done,
        input  busy,
        input  read_data
    );

    modport slave (
        input  bus_step,
        input  command_or_data,
        input  read_req,
        input  data_to_write,
        output bus_done,
        output busy,
        output read_data
    );
endinterface
`default_nettype wire

// File: rtl/hx8352_bus_if.sv
`default_nettype none
// ============================================================================
// Module      : hx8352_bus_if
// Description : 8080-style parallel bus engine for the HX8352 LCD. Turns each
//               accepted request into one timed write cycle (RS, WR_N, DATA)
//               or one read cycle (RD_N, turnaround, sampled DATA) and returns
//               a single-cycle bus_done.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               bus (slave)     - request/response handshake
//               lcd_rs          - register select
//               lcd_wr_n        - write strobe, active low
//               lcd_rd_n        - read strobe, active low
//               lcd_data_out    - driven pad value
//               lcd_data_oe     - 1 = drive lcd_data_out onto the pad
//               lcd_data_in     - pad input
// Revision    : 1.0 - initial release
// ============================================================================
module hx8352_bus_if #(
    parameter int unsigned SETUP_CYCLES   = 1,
    parameter int unsigned WR_LOW_CYCLES  = 2,
    parameter int unsigned WR_HIGH_CYCLES = 2,
    parameter int unsigned RD_LOW_CYCLES  = 8,
    parameter int unsigned RD_HIGH_CYCLES = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    hx8352_bus_if_if.slave   bus,
    output logic             lcd_rs,
    output logic             lcd_wr_n,
    output logic             lcd_rd_n,
    output logic [15:0]      lcd_data_out,
    output logic             lcd_data_oe,
    input  wire logic [15:0] lcd_data_in
);

    // Counter reload values: a state of N cycles loads N-1 and leaves at 0.
    localparam logic [7:0] c_setup_load   = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] c_wr_low_load  = 8'(WR_LOW_CYCLES - 1);
    localparam logic [7:0] c_wr_high_load = 8'(WR_HIGH_CYCLES - 1);
    localparam logic [7:0] c_rd_low_load  = 8'(RD_LOW_CYCLES - 1);
    localparam logic [7:0] c_rd_high_load = 8'(RD_HIGH_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        WR_LOW  = 3'd2,
        WR_HIGH = 3'd3,
        RD_TURN = 3'd4,
        RD_LOW  = 3'd5,
        RD_HIGH = 3'd6,
        DONE    = 3'd7
    } state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_rs;
    logic        r_wr_n;
    logic        r_rd_n;
    logic [15:0] r_data_out;
    logic        r_oe;
    logic [15:0] r_read_data;
    logic        r_bus_done;
    logic        r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= 8'd0;
            r_rs        <= 1'b0;
            r_wr_n      <= 1'b1;
            r_rd_n      <= 1'b1;
            r_data_out  <= 16'd0;
            r_oe        <= 1'b1;
            r_read_data <= 16'd0;
            r_bus_done  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_bus_done <= 1'b0;
            // Timed states count down here; the state that reaches zero
            // reloads the counter for its successor below.
            if (r_cnt != 8'd0) begin
                r_cnt <= r_cnt - 8'd1;
            end

            unique case (r_state)
                IDLE: begin
                    if (bus.bus_step) begin
                        r_busy <= 1'b1;
                        r_cnt  <= c_setup_load;
                        if (bus.read_req) begin
                            // Release the pad first; rs is forced high for
                            // reads and the write payload is ignored.
                            r_state <= RD_TURN;
                            r_oe    <= 1'b0;
                            r_rs    <= 1'b1;
                        end else begin
                            r_state    <= SETUP;
                            r_oe       <= 1'b1;
                            r_rs       <= bus.command_or_data;
                            r_data_out <= bus.data_to_write;
                        end
                    end
                end
                SETUP: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= WR_LOW;
                        r_cnt   <= c_wr_low_load;
                        r_wr_n  <= 1'b0;
                    end
                end
                WR_LOW: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= WR_HIGH;
                        r_cnt   <= c_wr_high_load;
                        r_wr_n  <= 1'b1;
                    end
                end
                WR_HIGH: begin
                    if (r_cnt == 8'd0) begin
                        r_state    <= DONE;
                        r_bus_done <= 1'b1;
                    end
                end
                RD_TURN: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= RD_LOW;
                        r_cnt   <= c_rd_low_load;
                        r_rd_n  <= 1'b0;
                    end
                end
                RD_LOW: begin
                    if (r_cnt == 8'd0) begin
                        // Sample only at the end of the strobe, when the
                        // panel's output has had the full low time to settle.
                        r_read_data <= lcd_data_in;
                        r_state     <= RD_HIGH;
                        r_cnt       <= c_rd_high_load;
                        r_rd_n      <= 1'b1;
                    end
                end
                RD_HIGH: begin
                    if (r_cnt == 8'd0) begin
                        r_state    <= DONE;
                        r_bus_done <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_oe    <= 1'b1;
                    r_cnt   <= 8'd0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_wr_n  <= 1'b1;
                    r_rd_n  <= 1'b1;
                    r_oe    <= 1'b1;
                    r_cnt   <= 8'd0;
                end
            endcase
        end
    end

    assign bus.bus_done  = r_bus_done;
    assign bus.busy      = r_busy;
    assign bus.read_data = r_read_data;

    assign lcd_rs       = r_rs;
    assign lcd_wr_n     = r_wr_n;
    assign lcd_rd_n     = r_rd_n;
    assign lcd_data_out = r_data_out;
    assign lcd_data_oe  = r_oe;

endmodule
`default_nettype wire

// File: doc/hx8352_bus_if.md
Name: hx8352_bus_if

Overview:
- 8080-style parallel bus engine for the HX8352 LCD. It is the responder to the main FSM's bus_step/command_or_data/data_to_write/bus_done handshake.
- Each accepted request becomes one timed write cycle on the panel pins (RS, WR_N, DATA) or one read cycle (RD_N, tri-state turnaround, sampled DATA).
- Returns a single-cycle bus_done per transaction.
- Read data (for example Product ID, register 0x00) is returned on read_data.

Parameters:
- SETUP_CYCLES, 1: RS/data setup (write) or bus turnaround (read) before the strobe falls; legal 1..255.
- WR_LOW_CYCLES, 2: WR_N low time; legal 1..255.
- WR_HIGH_CYCLES, 2: WR_N high hold after the rising edge before done; legal 1..255.
- RD_LOW_CYCLES, 8: RD_N low time; legal 1..255.
- RD_HIGH_CYCLES, 4: RD_N high recovery before done; legal 1..255.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- bus_step  in  1  request strobe; sampled only in IDLE.
- command_or_data  in  1  0 = command (RS low), 1 = data (RS high); ignored for reads.
- read_req  in  1  1 = read cycle, 0 = write cycle; sampled with bus_step.
- data_to_write  in  16  write payload; sampled with bus_step.
- bus_done  out  1  one-cycle pulse at transaction end.
- busy  out  1  high whenever state != IDLE.
- read_data  out  16  last sampled read value; held until the next read sample.
- lcd_rs  out  1  register select.
- lcd_wr_n  out  1  write strobe, active low.
- lcd_rd_n  out  1  read strobe, active low.
- lcd_data_out  out  16  driven bus value.
- lcd_data_oe  out  1  1 = drive lcd_data_out onto the pad.
- lcd_data_in  in  16  pad input.

Behaviour:
- Reset values (next edge with rst=1): state IDLE, lcd_wr_n=1, lcd_rd_n=1, lcd_rs=0, lcd_data_oe=1, lcd_data_out=0, read_data=0, bus_done=0, busy=0, cycle counter=0.
- All outputs are registered. No combinational path from inputs to pins.
- States: IDLE, SETUP, WR_LOW, WR_HIGH, RD_TURN, RD_LOW, RD_HIGH, DONE.
- IDLE, on bus_step=1:
  - latch command_or_data, read_req and data_to_write;
  - next state is SETUP (write) or RD_TURN (read).
- bus_step while busy is dropped: no queue, no error, latched values unchanged.
- Each timed state lasts exactly its parameter count of cycles. An 8-bit down-counter is loaded on state entry.
- Write path:
  - SETUP: lcd_rs = latched command_or_data, lcd_data_out = latched data, oe=1, wr_n=1.
  - WR_LOW: wr_n=0.
  - WR_HIGH: wr_n=1, data/rs held (panel latches on the rising edge).
  - Then DONE.
- Read path:
  - RD_TURN: oe=0, rs=1, rd_n=1.
  - RD_LOW: rd_n=0; lcd_data_in is registered into read_data on the final RD_LOW cycle only.
  - RD_HIGH: rd_n=1, oe stays 0.
  - Then DONE.
- DONE: bus_done=1 for exactly one cycle, then IDLE. read_data is valid in the bus_done cycle.
- On returning to IDLE: oe=1. rs and data_out hold their last values.
- Latency (bus_step high in cycle 0):
  - write: bus_done in cycle 1+SETUP+WR_LOW+WR_HIGH (defaults: 6);
  - read: bus_done in cycle 1+SETUP+RD_LOW+RD_HIGH (defaults: 14).
- Back-to-back: a bus_step arriving the cycle after bus_done (in IDLE) is accepted with no bubble beyond the IDLE cycle.
- lcd_wr_n and lcd_rd_n are never low simultaneously.
- oe is never 1 while rd_n=0.
- Reset mid-transaction: abort at the next edge; strobes return high, oe=1, no bus_done is issued. read_data is cleared to 0.

Test Plan:
- Command write, defaults: bus_step, cmd=0, data=0x0022 at cycle 0 -> rs=0, data_out=0x0022 from cycle 1; wr_n low cycles 2-3, high 4-5; single bus_done in cycle 6; busy cycles 1-6.
- Back-to-back data writes 0xF800 then 0x07E0, second bus_step the cycle after bus_done -> two WR_N low pulses of 2 cycles each, rs=1; data_out changes only on SETUP entry; two bus_done pulses 7 cycles apart.
- Read, read_req=1:
  - lcd_data_in = 0x0052 during RD_LOW, switched to 0xFFFF in RD_HIGH;
  - required: oe=0 one cycle before rd_n falls, rd_n low 8 cycles;
  - read_data=0x0052 at bus_done (cycle 14); oe=1 again in the following IDLE.
- bus_step with data 0x1234 asserted during WR_LOW of a 0x0022 write -> ignored; pins keep 0x0022; exactly one bus_done.
- rst pulsed during WR_LOW -> wr_n=1, busy=0 next cycle, no bus_done. A subsequent write of 0x00AA completes with the nominal 6-cycle latency.
- Override SETUP=2, WR_LOW=1, WR_HIGH=3, RD_LOW=3 -> write bus_done at cycle 7 and read bus_done at cycle 10 (RD_HIGH=4); strobe widths match the parameters.
